// File: rtl/aes_key_pkg.sv
// ---------------------------------------------------------------------------
// aes_key_pkg
// Types and tables shared by the AES-128 key schedule blocks (the forward
// and inverse key expansion).
//   state_e : inverse key-walk FSM states
//   RCON    : round constant for rounds 1..10, indexed by round number
//   SBOX    : forward AES S-box table
//   sbox()  : byte substitution through SBOX
// ---------------------------------------------------------------------------
package aes_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT,
        ST_W3,
        ST_W2,
        ST_W1,
        ST_W0,
        ST_COMPUTE,
        ST_DONE
    } state_e;

    // Index 0 and 11..15 never occur on a legal walk; they are kept at zero.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_g_word.sv
// ---------------------------------------------------------------------------
// key_g_word
// Combinational AES key-schedule g() function: RotWord, SubWord, then the
// round constant XORed into byte 0. Byte 0 of a word sits in bits [7:0].
//   word_i   [31:0] : input word (w3 of the earlier key)
//   round_i  [3:0]  : round number selecting Rcon
//   result_o [31:0] : g(word_i, round_i)
// ---------------------------------------------------------------------------
module key_g_word
    import aes_key_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [3:0]  round_i,
    output logic [31:0] result_o
);

    logic [31:0] rot;

    // Rotate one byte towards byte 0: new byte 0 is old byte 1.
    assign rot = {word_i[7:0], word_i[31:8]};

    assign result_o = {sbox(rot[31:24]),
                       sbox(rot[23:16]),
                       sbox(rot[15:8]),
                       sbox(rot[7:0]) ^ RCON[round_i]};

endmodule

// File: rtl/inv_key_expansion.sv
// ---------------------------------------------------------------------------
// inv_key_expansion
// Inverse AES-128 key schedule. Loads round key N and walks backward,
// presenting keys N, N-1, ... 0 one at a time over a valid/ready handshake.
// Word packing: w0 = [31:0] ... w3 = [127:96].
//
// Build option: define INV_KEY_FAST_EN to compute the whole previous key in
// one COMPUTE cycle (handshake-to-valid 2 cycles) instead of one word per
// cycle (handshake-to-valid 5 cycles). Key values and order are identical.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   start       : load request, sampled only in IDLE
//   start_round : round number of key_in (0..NUM_ROUNDS)
//   key_in      : round key for start_round
//   key_ready   : consumer accepts key_out
//   key_out     : current round key
//   round_out   : round number of key_out
//   key_valid   : key_out/round_out valid
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse after the round-0 key is accepted
//   err         : one-cycle pulse on an out-of-range start_round
// ---------------------------------------------------------------------------
module inv_key_expansion
    import aes_key_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   start_round,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

    state_e        state_q;
    logic [127:0]  key_q;
    logic [3:0]    round_q;
    logic          key_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [31:0]   w3_prev;
    logic [31:0]   g_in;
    logic [31:0]   g_out;

    assign w3_prev = key_q[127:96] ^ key_q[95:64];

`ifdef INV_KEY_FAST_EN
    assign g_in = w3_prev;
`else
    // By the W0 cycle, key_q.w3 already holds the previous key's w3.
    assign g_in = key_q[127:96];
`endif

    key_g_word u_g_word (
        .word_i   (g_in),
        .round_i  (round_q),
        .result_o (g_out)
    );

    // Word-serial walk updates key_q in place, w3 first: each step only reads
    // words that are still from the current key, except W0, which needs the
    // freshly written previous w3 for g().
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            round_q     <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_round <= MAX_ROUND) begin
                            key_q       <= key_in;
                            round_q     <= start_round;
                            key_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (key_ready) begin
                        key_valid_q <= 1'b0;
                        if (round_q == 4'd0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
`ifdef INV_KEY_FAST_EN
                            state_q <= ST_COMPUTE;
`else
                            state_q <= ST_W3;
`endif
                        end
                    end
                end
`ifdef INV_KEY_FAST_EN
                ST_COMPUTE: begin
                    key_q       <= {w3_prev,
                                    key_q[95:64] ^ key_q[63:32],
                                    key_q[63:32] ^ key_q[31:0],
                                    key_q[31:0]  ^ g_out};
                    round_q     <= round_q - 4'd1;
                    key_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
`else
                ST_W3: begin
                    key_q[127:96] <= w3_prev;
                    state_q       <= ST_W2;
                end
                ST_W2: begin
                    key_q[95:64] <= key_q[95:64] ^ key_q[63:32];
                    state_q      <= ST_W1;
                end
                ST_W1: begin
                    key_q[63:32] <= key_q[63:32] ^ key_q[31:0];
                    state_q      <= ST_W0;
                end
                ST_W0: begin
                    key_q[31:0] <= key_q[31:0] ^ g_out;
                    round_q     <= round_q - 4'd1;
                    key_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    key_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_out   = key_q;
    assign round_out = round_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_inv_key_expansion
// Directed bench for inv_key_expansion using the FIPS-197 AES-128 example
// key schedule (words byte-reversed into the w0=[31:0], byte0=[7:0] packing).
// Define INV_KEY_FAST_EN for both bench and RTL to check the fast build.
// ---------------------------------------------------------------------------
module tb_inv_key_expansion;

`ifdef INV_KEY_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 5;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   start_round;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        int           stall;   // cycles key_ready is held low at this key
        bit           poke;    // pulse start while this key is being computed
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    inv_key_expansion #(.NUM_ROUNDS(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_round (start_round),
        .key_in      (key_in),
        .key_ready   (key_ready),
        .key_out     (key_out),
        .round_out   (round_out),
        .key_valid   (key_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] r, input logic [127:0] k);
        start       = 1'b1;
        start_round = r;
        key_in      = k;
        tick();
        start       = 1'b0;
        key_in      = '0;
        start_round = 4'd0;
    endtask

    // Waits for the key of table entry idx, checks it, applies any stall,
    // then performs the handshake edge.
    task automatic take_key(input int idx, input bit check_lat);
        int lat;
        lat = 1;
        while (key_valid !== 1'b1 && lat < 40) begin
            if (tbl[idx].poke && lat == 1) begin
                start       = 1'b1;
                start_round = 4'd3;
                key_in      = '1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        check($sformatf("valid[%0d]", idx), 128'(key_valid), 128'd1);
        if (check_lat) check($sformatf("latency[%0d]", idx), 128'(lat), 128'(LAT));
        check($sformatf("key[%0d]", idx), key_out, tbl[idx].key);
        check($sformatf("round[%0d]", idx), 128'(round_out), 128'(tbl[idx].rnd));
        check($sformatf("busy[%0d]", idx), 128'(busy), 128'd1);
        if (tbl[idx].stall > 0) begin
            key_ready = 1'b0;
            for (int s = 0; s < tbl[idx].stall; s++) begin
                start       = 1'b1;
                start_round = 4'd2;
                key_in      = '1;
                tick();
                check($sformatf("stall_key[%0d]", s), key_out, tbl[idx].key);
                check($sformatf("stall_round[%0d]", s), 128'(round_out), 128'(tbl[idx].rnd));
                check($sformatf("stall_valid[%0d]", s), 128'(key_valid), 128'd1);
            end
            start     = 1'b0;
            key_in    = '0;
            key_ready = 1'b1;
        end
        tick();
    endtask

    initial begin
        int base;

        tbl[0]  = '{4'd10, 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0, 0, 1'b0};
        tbl[1]  = '{4'd9,  128'h6e005c57_4129d128_21dcfa19_f36677ac, 0, 1'b0};
        tbl[2]  = '{4'd8,  128'h2f298d7f_60f52b31_d2ba8db5_2173d2ea, 0, 1'b1};
        tbl[3]  = '{4'd7,  128'h4fdca64e_b24fa684_f3c95f5f_0ef7544e, 7, 1'b0};
        tbl[4]  = '{4'd6,  128'hfd9300ca_4186f9db_fd3e0b11_7aa3886d, 0, 1'b0};
        tbl[5]  = '{4'd5,  128'hbc15f911_bcb8f2ca_879d837c_f8c6d1d4, 0, 1'b0};
        tbl[6]  = '{4'd4,  128'h00ad0bdb_3b2571b6_7f5b52a8_41a544ef, 0, 1'b0};
        tbl[7]  = '{4'd3,  128'h3b887a6d_447e231e_3efe1647_7d47803d, 0, 1'b0};
        tbl[8]  = '{4'd2,  128'h7ff65973_7a803559_43b9967a_f295c2f2, 0, 1'b0};
        tbl[9]  = '{4'd1,  128'h05766c2a_3939a323_b12c5488_17fefaa0, 0, 1'b0};
        tbl[10] = '{4'd0,  128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, 0, 1'b0};

        rst         = 1'b1;
        start       = 1'b0;
        start_round = 4'd0;
        key_in      = '0;
        key_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_key",   key_out,           '0);
        check("rst_round", 128'(round_out),   '0);
        check("rst_valid", 128'(key_valid),   '0);
        check("rst_busy",  128'(busy),        '0);
        check("rst_done",  128'(done),        '0);
        check("rst_err",   128'(err),         '0);

        // Full walk 10 -> 0 with a stall at round 7 and mid-walk start pokes.
        base = done_cnt;
        do_start(4'd10, tbl[0].key);
        for (int i = 0; i <= 10; i++) take_key(i, i > 0);
        check("done_pulse", 128'(done), 128'd1);
        check("done_valid", 128'(key_valid), 128'd0);
        // start in the DONE cycle must be ignored.
        start       = 1'b1;
        start_round = 4'd10;
        key_in      = tbl[0].key;
        tick();
        start = 1'b0;
        check("done_clear", 128'(done), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        tick();
        check("done_start_ignored", 128'(key_valid), 128'd0);
        check("done_start_busy", 128'(busy), 128'd0);
        check("done_count", 128'(done_cnt - base), 128'd1);

        // Illegal start rounds.
        do_start(4'd11, tbl[0].key);
        check("err11", 128'(err), 128'd1);
        check("err11_busy", 128'(busy), 128'd0);
        check("err11_valid", 128'(key_valid), 128'd0);
        tick();
        check("err_clear", 128'(err), 128'd0);
        do_start(4'd15, tbl[0].key);
        check("err15", 128'(err), 128'd1);
        tick();
        check("err15_valid", 128'(key_valid), 128'd0);

        // start_round = 0: single key, then done.
        base = done_cnt;
        do_start(4'd0, tbl[10].key);
        take_key(10, 1'b0);
        check("r0_done", 128'(done), 128'd1);
        tick();
        check("r0_idle", 128'(busy), 128'd0);
        check("r0_count", 128'(done_cnt - base), 128'd1);

        // Reset mid-walk after accepting round 5 (in W2 for the serial build).
        base = done_cnt;
        do_start(4'd10, tbl[0].key);
        for (int i = 0; i <= 5; i++) take_key(i, i > 0);
        if (LAT == 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_key",   key_out,         '0);
        check("mid_rst_round", 128'(round_out), '0);
        check("mid_rst_valid", 128'(key_valid), '0);
        check("mid_rst_busy",  128'(busy),      '0);
        tick();
        check("mid_rst_nodone", 128'(done_cnt - base), 128'd0);
        do_start(4'd10, tbl[0].key);
        take_key(0, 1'b0);
        take_key(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
